expire_alarm: RTL and testbench
===============================

EXPIRE_ALARM -- requirements
Module: expire_alarm

Interface
REQ-001 SHALL have parameter BEEP_CYC, default 2_000_000, meaning clocks per beep-on and per beep-off phase (200 ms at 10 MHz).
REQ-002 SHALL have parameter BEEPS, default 3, meaning number of beeps per expiry (1..15).
REQ-003 SHALL have parameter WARN_CYC, default 500_000, meaning clocks per warning chirp (50 ms).
REQ-004 SHALL have parameter TONE_DIV, default 2500, meaning clocks per tone half-period (2 kHz at 10 MHz).
REQ-005 SHALL have port clk, input, 1 bit: single system clock (10 MHz domain).
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port seconds, input, 6 bits: current countdown value from the countdown state machine.
REQ-008 SHALL have port running, input, 1 bit: countdown running flag.
REQ-009 SHALL have port ack_p, input, 1 bit: one-clock silence pulse (any debounced key).
REQ-010 SHALL have port buzzer, output, 1 bit: tone drive to piezo.
REQ-011 SHALL have port alarm_active, output, 1 bit: high while the expiry sequence runs.
REQ-012 SHALL have port blank, output, 1 bit: display blank request; high during beep-off phases.
REQ-013 SHALL have port done_p, output, 1 bit: one-clock pulse when the expiry sequence completes or is acknowledged.

Function
REQ-014 SHALL register seconds and running each clock as sec_q and run_q.
REQ-015 SHALL raise the expiry event when seconds==0, sec_q==1 and run_q==1.
REQ-016 SHALL raise the warn event when running==1, seconds!=sec_q and seconds is 3, 2 or 1.
REQ-017 SHALL implement states IDLE, WARN, BEEP_ON and BEEP_OFF, using one phase counter and one beep counter.
REQ-018 IDLE: the expiry event SHALL go to BEEP_ON with beep count 0; the warn event SHALL go to WARN.
REQ-019 WARN: the state SHALL last WARN_CYC clocks and then return to IDLE; an expiry event SHALL go to BEEP_ON immediately; a warn event SHALL restart the chirp.
REQ-020 BEEP_ON: the state SHALL last BEEP_CYC clocks and then go to BEEP_OFF.
REQ-021 BEEP_OFF: the state SHALL last BEEP_CYC clocks; it SHALL then increment the beep count and go to BEEP_ON if the count is below BEEPS, else go to IDLE and assert done_p.
REQ-022 ack_p in BEEP_ON or BEEP_OFF SHALL go to IDLE on the next clock and assert done_p; ack_p SHALL be ignored in IDLE and WARN.
REQ-023 An expiry event during BEEP_ON or BEEP_OFF SHALL restart the sequence at BEEP_ON with beep count 0; if it coincides with ack_p, ack_p SHALL win.
REQ-024 A tone bit SHALL toggle every TONE_DIV clocks while in WARN or BEEP_ON, and SHALL clear to 0 on every state entry.
REQ-025 buzzer SHALL equal the tone bit in WARN or BEEP_ON, else 0.
REQ-026 alarm_active SHALL be high exactly in BEEP_ON or BEEP_OFF.
REQ-027 blank SHALL be high exactly in BEEP_OFF.
REQ-028 All outputs SHALL be registered; done_p SHALL be high for exactly one clock.
REQ-029 Counters SHALL be sized by $clog2 of their maximum and SHALL never wrap.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, clear all counters, sec_q and run_q, and set buzzer, alarm_active, blank and done_p to 0.
REQ-031 Reset deasserted mid-sequence SHALL resume in IDLE with no beep or done_p.
REQ-032 After reset, a stale seconds==0 SHALL NOT raise an expiry event, because sec_q==0.

Verification (BEEP_CYC=20, BEEPS=3, WARN_CYC=6, TONE_DIV=2)
REQ-033 Bench SHALL drive running=1 and seconds 4->3, then check one chirp: buzzer toggles every 2 clocks for 6 clocks, then 0; alarm_active stays 0.
REQ-034 Bench SHALL drive seconds 1->0 with running 1->0 in the same clock, then check 3 BEEP_ON/BEEP_OFF pairs of 20 clocks each, blank high 60 clocks total, alarm_active high 120 clocks, and a single done_p at the end.
REQ-035 Bench SHALL pulse ack_p 5 clocks into the 2nd BEEP_OFF, then check IDLE on the next clock, one done_p, and buzzer, blank and alarm_active all 0.
REQ-036 Bench SHALL raise an expiry event 3 clocks into a WARN chirp, then check BEEP_ON entered on the next clock with the tone bit restarted at 0.
REQ-037 Bench SHALL assert rst_n low during BEEP_ON with seconds held at 0, then check all outputs 0 asynchronously and no re-trigger after release.
REQ-038 Bench SHALL drive seconds 1->0 while running was 0 (paused), then check that no expiry event occurs and outputs stay 0.

Source files
------------

// File: rtl/expire_alarm.sv
`default_nettype none
// ============================================================================
//  Module   : expire_alarm
//  Purpose  : Countdown expiry alarm. Watches the countdown value and run flag,
//             emits a short warning chirp on each of the last three seconds and
//             a BEEPS-long beep/blank sequence when the countdown reaches zero
//             while running. Any acknowledge pulse silences the sequence.
//  Ports    : clk          - system clock
//             rst_n        - asynchronous active-low reset
//             seconds      - current countdown value
//             running      - countdown running flag
//             ack_p        - one-clock silence pulse
//             buzzer       - tone drive to piezo
//             alarm_active - high while the expiry sequence runs
//             blank        - display blank request (beep-off phases)
//             done_p       - one-clock pulse at sequence completion / ack
//  Revision : 1.0 - initial release
// ============================================================================
module expire_alarm #(
    parameter int BEEP_CYC = 2_000_000,
    parameter int BEEPS    = 3,
    parameter int WARN_CYC = 500_000,
    parameter int TONE_DIV = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] seconds,
    input  logic       running,
    input  logic       ack_p,
    output logic       buzzer,
    output logic       alarm_active,
    output logic       blank,
    output logic       done_p
);

    // One phase counter serves both WARN and the beep phases, so it is sized
    // for the longer of the two.
    localparam int PH_MAX = (BEEP_CYC > WARN_CYC) ? BEEP_CYC : WARN_CYC;
    localparam int PH_W   = ($clog2(PH_MAX)   > 0) ? $clog2(PH_MAX)   : 1;
    localparam int BC_W   = ($clog2(BEEPS)    > 0) ? $clog2(BEEPS)    : 1;
    localparam int TD_W   = ($clog2(TONE_DIV) > 0) ? $clog2(TONE_DIV) : 1;

    localparam logic [PH_W-1:0] C_WARN_LAST = PH_W'(WARN_CYC - 1);
    localparam logic [PH_W-1:0] C_BEEP_LAST = PH_W'(BEEP_CYC - 1);
    localparam logic [BC_W-1:0] C_BEEP_IDX  = BC_W'(BEEPS - 1);
    localparam logic [TD_W-1:0] C_TONE_LAST = TD_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WARN     = 2'd1,
        S_BEEP_ON  = 2'd2,
        S_BEEP_OFF = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BC_W-1:0]   beep_q,  beep_d;
    logic [TD_W-1:0]   tcnt_q,  tcnt_d;
    logic              tone_q,  tone_d;
    logic [5:0]        sec_q;
    logic              run_q;
    logic              done_d;
    logic              buzzer_q, alarm_q, blank_q, done_q;

    logic              w_expiry;
    logic              w_warn;
    logic              w_entry;

    // Expiry: the count stepped 1 -> 0 while it was running on the previous
    // clock. Looking at run_q (not running) lets the countdown FSM drop its
    // run flag on the same clock it reaches zero.
    assign w_expiry = (seconds == 6'd0) && (sec_q == 6'd1) && run_q;
    assign w_warn   = running && (seconds != sec_q) &&
                      (seconds >= 6'd1) && (seconds <= 6'd3);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        beep_d  = beep_q;
        tcnt_d  = tcnt_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        w_entry = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_expiry) begin
                    state_d = S_BEEP_ON;
                    beep_d  = '0;
                    w_entry = 1'b1;
                end else if (w_warn) begin
                    state_d = S_WARN;
                    w_entry = 1'b1;
                end
            end
            S_WARN: begin
                if (w_expiry) begin
                    state_d = S_BEEP_ON;
                    beep_d  = '0;
                    w_entry = 1'b1;
                end else if (w_warn) begin
                    // New second while chirping: restart the chirp.
                    w_entry = 1'b1;
                end else if (phase_q == C_WARN_LAST) begin
                    state_d = S_IDLE;
                    w_entry = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_BEEP_ON: begin
                if (ack_p) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    w_entry = 1'b1;
                end else if (w_expiry) begin
                    beep_d  = '0;
                    w_entry = 1'b1;
                end else if (phase_q == C_BEEP_LAST) begin
                    state_d = S_BEEP_OFF;
                    w_entry = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_BEEP_OFF: begin
                if (ack_p) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    w_entry = 1'b1;
                end else if (w_expiry) begin
                    state_d = S_BEEP_ON;
                    beep_d  = '0;
                    w_entry = 1'b1;
                end else if (phase_q == C_BEEP_LAST) begin
                    w_entry = 1'b1;
                    // beep_q is the index of the beep just finished.
                    if (beep_q == C_BEEP_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BEEP_ON;
                        beep_d  = beep_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                w_entry = 1'b1;
            end
        endcase

        // Every state entry (including re-entry) restarts phase and tone.
        if (w_entry) begin
            phase_d = '0;
            tcnt_d  = '0;
            tone_d  = 1'b0;
        end else if (state_q == S_WARN || state_q == S_BEEP_ON) begin
            if (tcnt_q == C_TONE_LAST) begin
                tcnt_d = '0;
                tone_d = ~tone_q;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with
    // state_q on the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            beep_q   <= '0;
            tcnt_q   <= '0;
            tone_q   <= 1'b0;
            sec_q    <= 6'd0;
            run_q    <= 1'b0;
            buzzer_q <= 1'b0;
            alarm_q  <= 1'b0;
            blank_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            beep_q   <= beep_d;
            tcnt_q   <= tcnt_d;
            tone_q   <= tone_d;
            sec_q    <= seconds;
            run_q    <= running;
            buzzer_q <= tone_d && (state_d == S_WARN || state_d == S_BEEP_ON);
            alarm_q  <= (state_d == S_BEEP_ON) || (state_d == S_BEEP_OFF);
            blank_q  <= (state_d == S_BEEP_OFF);
            done_q   <= done_d;
        end
    end

    assign buzzer       = buzzer_q;
    assign alarm_active = alarm_q;
    assign blank        = blank_q;
    assign done_p       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_expire_alarm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expire_alarm
//  Purpose  : Directed self-checking bench for expire_alarm with short
//             timing parameters (BEEP_CYC=20, BEEPS=3, WARN_CYC=6, TONE_DIV=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_expire_alarm;

    localparam int BEEP_CYC = 20;
    localparam int BEEPS    = 3;
    localparam int WARN_CYC = 6;
    localparam int TONE_DIV = 2;

    logic       clk;
    logic       rst_n;
    logic [5:0] seconds;
    logic       running;
    logic       ack_p;
    logic       buzzer;
    logic       alarm_active;
    logic       blank;
    logic       done_p;

    int n_checks = 0;
    int n_errors = 0;

    expire_alarm #(
        .BEEP_CYC (BEEP_CYC),
        .BEEPS    (BEEPS),
        .WARN_CYC (WARN_CYC),
        .TONE_DIV (TONE_DIV)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seconds      (seconds),
        .running      (running),
        .ack_p        (ack_p),
        .buzzer       (buzzer),
        .alarm_active (alarm_active),
        .blank        (blank),
        .done_p       (done_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int outs();
        return {28'd0, buzzer, alarm_active, blank, done_p};
    endfunction

    int buz_seq [7];
    int exp_buz [7] = '{0, 0, 1, 1, 0, 0, 0};
    int cnt_alarm, cnt_blank, cnt_buz, cnt_done, done_idx, bad;

    initial begin
        rst_n   = 1'b0;
        seconds = 6'd4;
        running = 1'b1;
        ack_p   = 1'b0;
        steps(3);
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        steps(3);
        check("idle_after_reset", outs(), 0);

        // ---- warning chirp: seconds 4 -> 3 ----
        seconds = 6'd3;
        for (int i = 0; i < 7; i++) begin
            step();
            buz_seq[i] = int'(buzzer);
            if (alarm_active) bad++;
        end
        for (int i = 0; i < 7; i++)
            check($sformatf("warn_buzzer[%0d]", i), buz_seq[i], exp_buz[i]);
        check("warn_no_alarm", bad, 0);

        // ---- full expiry sequence ----
        seconds = 6'd1;          // another chirp; let it finish
        steps(8);
        check("pre_expiry_idle", outs(), 0);
        seconds = 6'd0;
        running = 1'b0;
        cnt_alarm = 0; cnt_blank = 0; cnt_buz = 0; cnt_done = 0; done_idx = -1;
        for (int i = 0; i < 130; i++) begin
            step();
            if (i == 0) check("expiry_enter_on", outs(), 4);   // alarm only
            if (i == 20) check("first_beep_off", outs(), 6);   // alarm+blank
            cnt_alarm += int'(alarm_active);
            cnt_blank += int'(blank);
            cnt_buz   += int'(buzzer);
            if (done_p) begin
                cnt_done++;
                done_idx = i;
            end
        end
        check("alarm_clocks", cnt_alarm, 120);
        check("blank_clocks", cnt_blank, 60);
        check("buzzer_high_clocks", cnt_buz, 30);
        check("done_count", cnt_done, 1);
        check("done_position", done_idx, 120);
        check("after_sequence_idle", outs(), 0);

        // ---- acknowledge in 2nd BEEP_OFF ----
        running = 1'b1;
        seconds = 6'd1;
        steps(8);
        seconds = 6'd0;
        step();                  // BEEP_ON entered here (index 0)
        check("ack_run_enter", outs(), 4);
        steps(64);               // 5th clock of the 2nd BEEP_OFF
        check("ack_pre_blank", outs(), 6);
        ack_p = 1'b1;
        step();
        ack_p = 1'b0;
        check("ack_idle_done", outs(), 1);
        step();
        check("ack_done_single", outs(), 0);
        steps(25);
        check("ack_stays_idle", outs(), 0);

        // ---- expiry three clocks into a chirp ----
        seconds = 6'd1;          // 0 -> 1 while running: warn
        steps(3);
        check("warn_tone_before_expiry", outs(), 8);   // buzzer high
        seconds = 6'd0;
        step();
        check("expiry_from_warn", outs(), 4);          // tone restarted at 0
        step();
        check("beep_tone_clk1", outs(), 4);
        step();
        check("beep_tone_clk2", outs(), 12);           // buzzer + alarm

        // ---- asynchronous reset during BEEP_ON, seconds held at 0 ----
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        step();
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (outs() != 0) bad++;
        end
        check("no_retrigger_after_reset", bad, 0);

        // ---- 1 -> 0 while paused ----
        running = 1'b0;
        seconds = 6'd1;
        steps(3);
        seconds = 6'd0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (outs() != 0) bad++;
        end
        check("paused_no_expiry", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial bad = 0;

endmodule
`default_nettype wire
